// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_pkg: shared types and constants for the sequential binary-to-BCD
// converter (bin_to_bcd_seq) and its per-digit adjust cell.
//   state_t         : converter FSM states
//   BCD_ADJ_*       : double-dabble add-3 rule (digit >= 5 -> digit + 3)
//   DATA_W_DEF/DIGITS_DEF : default binary width / BCD digit count
package bin_to_bcd_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DIGITS_DEF = 10;  // 10^10 > 2^32

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: valid/ready bus around the BCD converter.
//   in_data/in_valid/in_ready     : binary value from upstream (Fibonacci source)
//   bcd_out/out_valid/out_ready   : packed BCD toward the display driver
//   digit_blank                   : leading-zero mask (only with BIN_TO_BCD_BLANK_EN)
// Modports:
//   master : the side that supplies data and consumes results (upstream + display)
//   slave  : the converter itself
interface bin_to_bcd_seq_if
  import bin_to_bcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
);

  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                out_valid;
  logic                out_ready;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0]   digit_blank;
`endif

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, bcd_out, out_valid
`ifdef BIN_TO_BCD_BLANK_EN
    , input digit_blank
`endif
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, bcd_out, out_valid
`ifdef BIN_TO_BCD_BLANK_EN
    , output digit_blank
`endif
  );

endinterface

// File: rtl/bin_to_bcd_seq_adjust.sv
// bcd_digit_adjust: combinational double-dabble correction for one BCD digit.
//   i_digit : 4-bit working digit
//   o_digit : i_digit + 3 when i_digit >= 5, else i_digit (no carry out)
module bcd_digit_adjust
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter.
// One add-3/shift iteration per clock; a result appears DATA_W edges after
// the accepting edge and is held until the downstream handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : bin_to_bcd_seq_if.slave (input handshake, BCD output handshake)
// Optional feature macro: BIN_TO_BCD_BLANK_EN adds the registered digit_blank
// leading-zero mask on the bus.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
)(
  input  logic              clk,
  input  logic              reset,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_bin;
  logic [BCD_W-1:0]    r_bcd_work;
  logic [CNT_W-1:0]    r_cnt;
  logic [BCD_W-1:0]    r_bcd_out;

  logic                w_load, w_shift, w_done;
  logic                w_in_ready, w_out_valid;
  logic [BCD_W-1:0]    w_adj;
  logic [BCD_W+DATA_W-1:0] w_work_nxt;
  logic [BCD_W-1:0]    w_bcd_nxt;
  logic [DATA_W-1:0]   w_bin_nxt;

  // add-3 on every digit, then shift the joined {bcd, bin} left by one
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .i_digit (r_bcd_work[4*g +: 4]),
        .o_digit (w_adj[4*g +: 4])
      );
    end
  endgenerate

  assign w_work_nxt = {w_adj, r_bin} << 1;
  assign w_bcd_nxt  = w_work_nxt[BCD_W+DATA_W-1 -: BCD_W];
  assign w_bin_nxt  = w_work_nxt[DATA_W-1:0];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state / control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_done      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin      <= '0;
      r_bcd_work <= '0;
      r_cnt      <= '0;
      r_bcd_out  <= '0;
    end else begin
      if (w_load) begin
        r_bin      <= bus.in_data;
        r_bcd_work <= '0;
        r_cnt      <= '0;
      end else if (w_shift) begin
        r_bin      <= w_bin_nxt;
        r_bcd_work <= w_bcd_nxt;
        r_cnt      <= r_cnt + CNT_W'(1);
      end
      // the last shift result goes straight to the output register
      if (w_done) r_bcd_out <= w_bcd_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.bcd_out   = r_bcd_out;

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank, w_blank;

  // digit i blanks when it and every digit above it are zero; digit 0 never blanks
  always_comb begin
    logic zero_above;
    w_blank    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (w_bcd_nxt[4*i +: 4] == 4'd0);
      w_blank[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_blank <= '0;
    else if (w_done) r_blank <= w_blank;
  end

  assign bus.digit_blank = r_blank;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: scoreboard of expected BCD values,
// latency, backpressure hold, ignored in_valid during SHIFT, async reset abort.
module tb_bin_to_bcd_seq;

  localparam int DATA_W = 32;
  localparam int DIGITS = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus();

  bin_to_bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // decimal digits by repeated division
  function automatic logic [63:0] ref_bcd(input longint unsigned v);
    logic [63:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_blank(input logic [63:0] b);
    logic [63:0] r;
    bit z;
    r = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z && (b[4*i +: 4] == 4'd0);
      r[i] = z;
    end
    return r;
  endfunction

  // drive one value and wait for the accepting edge; ends 1 time unit after it
  task automatic start(input logic [31:0] v);
    @(negedge clk);
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    exp_q.push_back(ref_bcd(64'(v)));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic convert(input logic [31:0] v, input int hold, input bit junk);
    int lat;
    bit stable;
    logic [63:0] exp;
    start(v);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (junk && lat == 10) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
      end
      if (junk && lat == 11) begin
        bus.in_valid = 1'b0;
        bus.in_data  = v;
      end
    end while (!bus.out_valid && lat < 100);
    chk("latency", 64'(lat), 64'(DATA_W));
    exp = exp_q.pop_front();
    chk("bcd_out", 64'(bus.bcd_out), exp);
`ifdef BIN_TO_BCD_BLANK_EN
    chk("digit_blank", 64'(bus.digit_blank), ref_blank(exp));
`endif
    chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (bus.bcd_out !== exp[4*DIGITS-1:0] || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
          stable = 1'b0;
      end
      chk("hold_stable", 64'(stable), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("out_valid_clr", 64'(bus.out_valid), 64'd0);
    chk("in_ready_back", 64'(bus.in_ready), 64'd1);
    chk("bcd_keep", 64'(bus.bcd_out), exp);
  endtask

  initial begin
    longint unsigned fa, fb, fc;
    reset         = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_bcd_out", 64'(bus.bcd_out), 64'd0);
`ifdef BIN_TO_BCD_BLANK_EN
    chk("rst_blank", 64'(bus.digit_blank), 64'd0);
`endif
    @(negedge clk) reset = 1'b0;

    convert(32'd0, 0, 1'b0);
    convert(32'd832040, 0, 1'b0);
    convert(32'hFFFFFFFF, 0, 1'b0);
    convert(32'd1346269, 50, 1'b0);

    // Fibonacci F1..F47, with a stray in_valid during every other SHIFT
    fa = 1;
    fb = 1;
    for (int k = 1; k <= 47; k++) begin
      convert(32'(fa), 0, (k % 2) == 0);
      fc = fa + fb;
      fa = fb;
      fb = fc;
    end

    // async reset in the middle of a conversion
    start(32'd123456789);
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_bcd_out", 64'(bus.bcd_out), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    void'(exp_q.pop_front());
    @(negedge clk) reset = 1'b0;
    convert(32'd7, 0, 1'b0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
